ram_port_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the single-port data block RAM behind the MIO bus. It shares the RAM between the CPU data port (master 0) and an auxiliary master (master 1, e.g. a switch/button entry writer or debug loader) using round-robin arbitration. It drives the RAM address, write-enable and write data, absorbs the RAM's one-cycle synchronous read latency, and returns read data with a per-master acknowledge. Master 0's acknowledge serves as the CPU's `MIO_ready` stall handshake.

---
 rtl/mio_pkg.sv | 12 +
 rtl/ram_port_arbiter_rr_arb2.sv | 15 +
 rtl/ram_port_arbiter.sv | 103 ++++++++++
 tb/tb_ram_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared types for the MIO data-RAM port: arbiter FSM states and master indices.
package mio_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int M_CPU = 0;
  localparam int M_AUX = 1;
endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the master that
// did not win last time wins.
module rr_arb2
  import mio_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[M_CPU] && (!req[M_AUX] || last)) gnt[M_CPU] = 1'b1;
    else if (req[M_AUX])                      gnt[M_AUX] = 1'b1;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port synchronous block RAM between the CPU data port and an
// auxiliary master; every access takes IDLE -> ISSUE -> CAPTURE -> RESP.
module ram_port_arbiter
  import mio_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);
  arb_state_t    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    req, gnt_oh;

  assign req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (gnt_oh)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = gnt_oh[M_AUX];
          last_d  = gnt_oh[M_AUX];
          we_d    = gnt_oh[M_AUX] ? m1_we : m0_we;
          addr_d  = gnt_oh[M_AUX] ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
          wdata_d = gnt_oh[M_AUX] ? m1_wdata : m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // RAM output for the ISSUE-edge address is valid throughout this cycle
        if (!we_q) rdata_d = ram_dout;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // addr/wdata only change on the edge into ISSUE, so they hold between accesses
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign ram_we   = (state_q == ISSUE) && we_q;
  assign m0_ack   = (state_q == RESP) && !gnt_q;
  assign m1_ack   = (state_q == RESP) && gnt_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed access table, multi-cycle corner sequences and
// a randomized two-master run against a transaction-level model.
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, ram_we, busy;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [9:0]  ram_addr;

  ram_port_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0101);
  endfunction

  // Synchronous-read single-port RAM
  logic [31:0] mem [1024];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  logic [31:0] shadow [1024];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit m, input bit r, input bit we, input logic [31:0] a,
                     input logic [31:0] d);
    if (!m) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  // Single access from idle, entered just after a rising edge
  task automatic access(input bit m, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [9:0] era,
                        input logic [31:0] erd);
    int ackk, wec;
    logic [31:0] rd;
    ackk = -1; wec = 0; rd = '0;
    drv(m, 1'b1, we, a, wd);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ram_we) wec++;
      if (k == 1) chk("acc_ram_addr", ram_addr, era);
      if (m ? m1_ack : m0_ack) begin ackk = k; rd = rdata; end
      if (m ? m0_ack : m1_ack) ackk = -2;
      @(posedge clk); #1;
    end
    drv(m, 1'b0, we, a, wd);
    chk("acc_ack_cycle", ackk, 3);
    chk("acc_we_pulses", wec, {31'd0, we});
    if (!we) chk("acc_rdata", rd, erd);
    else shadow[era] = wd;
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_ra;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          m;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    txn_t q [$];
    int a0, a1, both, n, cnt0, cnt1, lt0, lt1, gap, wecnt, busybad, ackn, idx;
    int ord [8];
    logic [31:0] rd0, rd1, bwd [3];
    int next_free;
    bit mlast, stop, e0, e1;
    bit ackd [2], rq [2], rwe [2];
    logic [31:0] ra [2], rdv [2];
    logic [31:0] tmp;

    rst = 1'b1; mem_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    @(negedge clk);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;

    tbl[0] = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 10'd4,     32'h0};
    tbl[1] = '{0, 0, 32'h0000_0010, 32'h0,         10'd4,     32'hDEAD_BEEF};
    tbl[2] = '{1, 1, 32'h0000_1004, 32'h5A5A_5A5A, 10'd1,     32'h0};
    tbl[3] = '{0, 0, 32'h0000_0004, 32'h0,         10'd1,     32'h5A5A_5A5A};
    tbl[4] = '{0, 0, 32'hFFFF_FFFF, 32'h0,         10'h3FF,   pat(10'h3FF)};
    tbl[5] = '{1, 1, 32'h0000_0008, 32'h1234_5678, 10'd2,     32'h0};
    tbl[6] = '{1, 0, 32'h8000_000B, 32'h0,         10'd2,     32'h1234_5678};
    for (int i = 0; i < 7; i++)
      access(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_ra, tbl[i].exp_rd);

    // Simultaneous reads right after a reset: m0 wins the first tie
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    drv(0, 1, 0, 32'h20, 0); drv(1, 1, 0, 32'h24, 0);
    a0 = -1; a1 = -1; both = 0; rd0 = '0; rd1 = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m0_ack) begin a0 = k; rd0 = rdata; end
      if (m1_ack) begin a1 = k; rd1 = rdata; end
      if (m0_ack && m1_ack) both++;
      @(posedge clk); #1;
      if (k == a0) drv(0, 0, 0, 32'h20, 0);
      if (k == a1) drv(1, 0, 0, 32'h24, 0);
    end
    chk("sim_m0_ack_cycle", a0, 3);
    chk("sim_m1_ack_cycle", a1, 7);
    chk("sim_m0_rdata", rd0, shadow[8]);
    chk("sim_m1_rdata", rd1, shadow[9]);
    chk("sim_acks_overlap", both, 0);

    // Fairness: both hold req; m1 won last, so m0 leads
    drv(0, 1, 0, 32'h30, 0); drv(1, 1, 0, 32'h34, 0);
    n = 0; cnt0 = 0; cnt1 = 0; lt0 = -1; lt1 = -1; gap = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge clk);
      if (m0_ack) begin
        ord[n] = 0; n++; cnt0++;
        if (lt0 >= 0 && k - lt0 > gap) gap = k - lt0;
        lt0 = k;
      end
      if (m1_ack) begin
        ord[n] = 1; n++; cnt1++;
        if (lt1 >= 0 && k - lt1 > gap) gap = k - lt1;
        lt1 = k;
      end
      @(posedge clk); #1;
    end
    drv(0, 0, 0, 32'h30, 0); drv(1, 0, 0, 32'h34, 0);
    chk("fair_ack_total", n, 8);
    for (int i = 0; i < 8; i++) chk("fair_order", ord[i], i % 2);
    chk("fair_m0_count", cnt0, 4);
    chk("fair_m1_count", cnt1, 4);
    chk("fair_gap_le8", gap <= 8, 1);

    // Reset during CAPTURE abandons the read
    @(posedge clk); #1;
    drv(0, 1, 0, 32'h40, 0);
    repeat (2) @(posedge clk);
    #1 chk("rstcap_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstcap_busy", busy, 0);
    chk("rstcap_rdata", rdata, 0);
    chk("rstcap_m0_ack", m0_ack, 0);
    chk("rstcap_ram_we", ram_we, 0);
    drv(0, 0, 0, 32'h40, 0);
    a0 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m0_ack) a0++;
      @(posedge clk); #1;
      if (k == 0) rst = 1'b0;
    end
    chk("rstcap_no_ack", a0, 0);
    access(0, 0, 32'h40, 0, 10'h10, shadow[16]);

    // m1 back-to-back writes, req re-presented on each ack edge
    bwd[0] = 32'h1111_0001; bwd[1] = 32'h1111_0002; bwd[2] = 32'h1111_0003;
    idx = 0; wecnt = 0; busybad = 0; ackn = 0;
    drv(1, 1, 1, 32'h50, bwd[0]);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ram_we) wecnt++;
      if (busy !== (k % 4 != 0)) busybad++;
      e1 = m1_ack;
      if (e1) ackn++;
      @(posedge clk); #1;
      if (e1) begin
        shadow[10'h14 + idx] = bwd[idx];
        idx++;
        if (idx < 3) drv(1, 1, 1, 32'h50 + 4 * idx, bwd[idx]);
        else drv(1, 0, 0, 32'h0, 0);
      end
    end
    chk("b2b_we_pulses", wecnt, 3);
    chk("b2b_busy_pattern_errs", busybad, 0);
    chk("b2b_acks", ackn, 3);
    access(0, 0, 32'h54, 0, 10'h15, 32'h1111_0002);

    // Randomized two-master run against a transaction-level model
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    next_free = 0; mlast = 1'b1; stop = 1'b0;
    for (int m = 0; m < 2; m++) begin ackd[m] = 0; rq[m] = 0; rwe[m] = 0; ra[m] = 0; rdv[m] = 0; end
    for (int c = 0; c < 700; c++) begin
      stop = (c >= 600);
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (ackd[m]) begin rq[m] = 0; ackd[m] = 0; end
        if (!rq[m] && !stop && $urandom_range(2) == 0) begin
          tmp    = $urandom;
          rq[m]  = 1;
          rwe[m] = 1'($urandom_range(1));
          ra[m]  = (tmp & 32'hFFFF_F003) | 32'h100 | (32'($urandom_range(15)) << 2);
          rdv[m] = $urandom;
        end
        drv(m[0], rq[m], rwe[m], ra[m], rdv[m]);
      end
      @(negedge clk);
      chk("rnd_busy", busy, c < next_free);
      e0 = (q.size() > 0) && (q[0].cyc == c) && !q[0].m;
      e1 = (q.size() > 0) && (q[0].cyc == c) && q[0].m;
      chk("rnd_m0_ack", m0_ack, e0);
      chk("rnd_m1_ack", m1_ack, e1);
      if (q.size() > 0 && q[0].cyc - 2 == c) begin
        chk("rnd_ram_we", ram_we, q[0].we);
        chk("rnd_ram_addr", ram_addr, q[0].a[11:2]);
        if (q[0].we) chk("rnd_ram_din", ram_din, q[0].d);
      end else begin
        chk("rnd_ram_we_idle", ram_we, 0);
      end
      if (e0 || e1) begin
        if (q[0].we) shadow[q[0].a[11:2]] = q[0].d;
        else chk("rnd_rdata", rdata, shadow[q[0].a[11:2]]);
        ackd[q[0].m] = 1;
        void'(q.pop_front());
      end
      if (c >= next_free && (m0_req || m1_req)) begin
        txn_t t;
        t.m   = (m0_req && m1_req) ? !mlast : m1_req;
        t.cyc = c + 3;
        t.we  = t.m ? m1_we : m0_we;
        t.a   = t.m ? m1_addr : m0_addr;
        t.d   = t.m ? m1_wdata : m0_wdata;
        q.push_back(t);
        mlast = t.m;
        next_free = c + 4;
      end
    end
    chk("rnd_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
